flappy_game_ctrl: RTL and testbench



---
 rtl/flappy_pkg.sv | 26 ++
 rtl/flappy_lfsr.sv | 23 ++
 rtl/flappy_game_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird game-state engine.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int COORD_W   = 11;
  localparam int SCORE_W   = 10;
  localparam int SCORE_MAX = 999;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_wide_t;

  // Gap heights handed out in rotation when random gaps are disabled
  localparam coord_t GAP_TABLE [4] = '{coord_t'(200), coord_t'(120), coord_t'(280), coord_t'(160)};

  function automatic coord_t gap_lookup(input logic [1:0] idx);
    return GAP_TABLE[idx];
  endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) for random pipe gaps.
// Only present when GAME_RANDOM_GAP_EN is defined.
`ifdef GAME_RANDOM_GAP_EN
module flappy_lfsr (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'hA5;
    end else begin
      q <= {q[6:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-state engine: bird physics, pipe scrolling, collision, score, IDLE/PLAY/DEAD.
// Define GAME_RANDOM_GAP_EN to take new gap heights from flappy_lfsr instead of the fixed table.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int BIRD_X    = 100,
  parameter int BIRD_SIZE = 16,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int GRAVITY   = 1,
  parameter int FLAP_V    = 6,
  parameter int VMAX      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 flap,
  output logic [COORD_W-1:0]   bird_x,
  output logic [COORD_W-1:0]   bird_y,
  output logic [COORD_W-1:0]   pipe1_x,
  output logic [COORD_W-1:0]   pipe1_y,
  output logic [COORD_W-1:0]   pipe2_x,
  output logic [COORD_W-1:0]   pipe2_y,
  output logic [SCORE_W-1:0]   score,
  output logic                 playing,
  output logic                 game_over
);

  localparam coord_t BIRD_Y0  = coord_t'(232);
  localparam coord_t PIPE1_X0 = coord_t'(639);
  localparam coord_t PIPE2_X0 = coord_t'(959);
  localparam coord_t PIPE1_Y0 = coord_t'(200);
  localparam coord_t PIPE2_Y0 = coord_t'(250);
  localparam coord_t WRAP_X   = coord_t'(SCREEN_W - 1);
  localparam coord_t PASS_X   = coord_t'(BIRD_X - PIPE_W - 1);

  localparam coord_wide_t BIRD_X_W     = coord_wide_t'(BIRD_X);
  localparam coord_wide_t BIRD_RIGHT_W = coord_wide_t'(BIRD_X + BIRD_SIZE);
  localparam coord_wide_t BIRD_SZ_W    = coord_wide_t'(BIRD_SIZE);
  localparam coord_wide_t PIPE_W_W     = coord_wide_t'(PIPE_W);
  localparam coord_wide_t GAP_H_W      = coord_wide_t'(GAP_H);
  localparam coord_wide_t SCREEN_H_W   = coord_wide_t'(SCREEN_H);

  localparam logic signed [9:0] GRAV_S   = 10'(GRAVITY);
  localparam logic signed [9:0] VMAX_S   = 10'(VMAX);
  localparam logic signed [7:0] FLAP_NEG = 8'(-FLAP_V);

  game_state_t state, state_next;

  logic              flap_prev, flap_pend, flap_rise, flap_eff;
  logic signed [7:0] vel, vel_next;
  logic signed [9:0] vel_wide, vel_sum;
  logic [7:0]        vel_abs;
  coord_t            bird_y_next;
  coord_t            pipe1_x_next, pipe2_x_next;
  coord_t            gap1_new, gap2_new;
  logic              pipe1_wrap, pipe2_wrap, pipe1_pass, pipe2_pass;
  logic [SCORE_W-1:0] score_base, score_next;
  logic [SCORE_W:0]   score_sum;
  logic              floor_hit, collision;
  logic              do_update, do_reload, clear_score;

  // Bird is outside the gap while horizontally overlapping this pipe
  function automatic logic pipe_hit(input coord_t px, input coord_t py, input coord_t by);
    logic overlap, outside;
    overlap = ({1'b0, px} < BIRD_RIGHT_W) && (({1'b0, px} + PIPE_W_W) > BIRD_X_W);
    outside = (by < py) || (({1'b0, by} + BIRD_SZ_W) > ({1'b0, py} + GAP_H_W));
    return overlap && outside;
  endfunction

  assign bird_x    = coord_t'(BIRD_X);
  assign playing   = (state == PLAY);
  assign game_over = (state == DEAD);

  // A flap edge coinciding with a tick is honoured on that same tick
  assign flap_rise = flap & ~flap_prev;
  assign flap_eff  = flap_pend | flap_rise;

  assign floor_hit = ({1'b0, bird_y} + BIRD_SZ_W) >= SCREEN_H_W;
  assign collision = (state == PLAY) &&
                     (floor_hit || pipe_hit(pipe1_x, pipe1_y, bird_y) || pipe_hit(pipe2_x, pipe2_y, bird_y));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Collision outranks a simultaneous tick, so the update is dropped on entry to DEAD
  always_comb begin
    state_next  = state;
    do_update   = 1'b0;
    do_reload   = 1'b0;
    clear_score = 1'b0;
    case (state)
      IDLE: begin
        if (tick && flap_eff) begin
          state_next  = PLAY;
          do_update   = 1'b1;
          clear_score = 1'b1;
        end
      end
      PLAY: begin
        if (collision) begin
          state_next = DEAD;
        end else if (tick) begin
          do_update = 1'b1;
        end
      end
      DEAD: begin
        if (tick && flap_eff) begin
          state_next = IDLE;
          do_reload  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    vel_wide = {{2{vel[7]}}, vel};
    vel_sum  = vel_wide + GRAV_S;
    if (flap_eff) begin
      vel_next = FLAP_NEG;
    end else if (vel_sum > VMAX_S) begin
      vel_next = VMAX_S[7:0];
    end else begin
      vel_next = vel_sum[7:0];
    end

    vel_abs = vel_next[7] ? 8'(-vel_next) : vel_next;
    if (vel_next[7]) begin
      bird_y_next = (bird_y < {3'b000, vel_abs}) ? '0 : bird_y - {3'b000, vel_abs};
    end else begin
      bird_y_next = bird_y + {3'b000, vel_abs};
    end
  end

  always_comb begin
    pipe1_wrap   = (pipe1_x == '0);
    pipe2_wrap   = (pipe2_x == '0);
    pipe1_x_next = pipe1_wrap ? WRAP_X : pipe1_x - coord_t'(1);
    pipe2_x_next = pipe2_wrap ? WRAP_X : pipe2_x - coord_t'(1);
    pipe1_pass   = (pipe1_x_next == PASS_X);
    pipe2_pass   = (pipe2_x_next == PASS_X);

    score_base = clear_score ? '0 : score;
    score_sum  = {1'b0, score_base} + {{SCORE_W{1'b0}}, pipe1_pass} + {{SCORE_W{1'b0}}, pipe2_pass};
    score_next = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
  end

`ifdef GAME_RANDOM_GAP_EN
  logic [7:0] lfsr_q;

  flappy_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  always_comb begin
    gap1_new = coord_t'(40) + {3'b000, lfsr_q};
    gap2_new = gap1_new;
  end
`else
  logic [1:0] gap_idx, gap_idx_next;

  // When both pipes wrap together, pipe2 takes the entry after pipe1's
  always_comb begin
    gap1_new     = gap_lookup(gap_idx);
    gap2_new     = pipe1_wrap ? gap_lookup(gap_idx + 2'd1) : gap_lookup(gap_idx);
    gap_idx_next = gap_idx + {1'b0, pipe1_wrap} + {1'b0, pipe2_wrap};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_idx <= '0;
    end else if (do_reload) begin
      gap_idx <= '0;
    end else if (do_update) begin
      gap_idx <= gap_idx_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flap_prev <= 1'b0;
      flap_pend <= 1'b0;
      bird_y    <= BIRD_Y0;
      vel       <= '0;
      pipe1_x   <= PIPE1_X0;
      pipe2_x   <= PIPE2_X0;
      pipe1_y   <= PIPE1_Y0;
      pipe2_y   <= PIPE2_Y0;
      score     <= '0;
    end else begin
      flap_prev <= flap;
      flap_pend <= tick ? 1'b0 : flap_eff;
      if (do_reload) begin
        bird_y  <= BIRD_Y0;
        vel     <= '0;
        pipe1_x <= PIPE1_X0;
        pipe2_x <= PIPE2_X0;
        pipe1_y <= PIPE1_Y0;
        pipe2_y <= PIPE2_Y0;
      end else if (do_update) begin
        bird_y  <= bird_y_next;
        vel     <= vel_next;
        pipe1_x <= pipe1_x_next;
        pipe2_x <= pipe2_x_next;
        if (pipe1_wrap) pipe1_y <= gap1_new;
        if (pipe2_wrap) pipe2_y <= gap2_new;
        score   <= score_next;
      end
    end
  end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl (default fixed-gap build) against a behavioural game model.
module tb_flappy_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        flap = 1'b0;
  logic [10:0] bird_x, bird_y, pipe1_x, pipe1_y, pipe2_x, pipe2_y;
  logic [9:0]  score;
  logic        playing, game_over;

  always #5 clk = ~clk;

  flappy_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .flap      (flap),
    .bird_x    (bird_x),
    .bird_y    (bird_y),
    .pipe1_x   (pipe1_x),
    .pipe1_y   (pipe1_y),
    .pipe2_x   (pipe2_x),
    .pipe2_y   (pipe2_y),
    .score     (score),
    .playing   (playing),
    .game_over (game_over)
  );

  logic [77:0] dut_vec;
  assign dut_vec = {bird_x, bird_y, pipe1_x, pipe1_y, pipe2_x, pipe2_y, score, playing, game_over};

  localparam logic [77:0] RESET_VEC = {11'd100, 11'd232, 11'd639, 11'd200, 11'd959, 11'd250, 10'd0, 1'b0, 1'b0};

  int tests = 0;
  int fails = 0;

  // Behavioural model: 0=idle 1=play 2=dead
  int m_state, m_by, m_vel, m_score, m_gidx;
  int m_px[2];
  int m_py[2];
  bit m_pend, m_fprev;
  int gap_table[4] = '{200, 120, 280, 160};

  function automatic logic [77:0] model_vec();
    return {11'd100, 11'(m_by), 11'(m_px[0]), 11'(m_py[0]), 11'(m_px[1]), 11'(m_py[1]),
            10'(m_score), (m_state == 1), (m_state == 2)};
  endfunction

  task automatic model_reload();
    m_by = 232; m_vel = 0; m_gidx = 0;
    m_px[0] = 639; m_px[1] = 959;
    m_py[0] = 200; m_py[1] = 250;
  endtask

  task automatic model_reset();
    model_reload();
    m_score = 0; m_state = 0; m_pend = 0; m_fprev = 0;
  endtask

  function automatic bit model_collide();
    if (m_by + 16 >= 480) return 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (m_px[i] < 116 && m_px[i] + 40 > 100 && (m_by < m_py[i] || m_by + 16 > m_py[i] + 120))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_update(input bit feff);
    m_vel = feff ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
    m_by = m_by + m_vel;
    if (m_by < 0) m_by = 0;
    for (int i = 0; i < 2; i++) begin
      if (m_px[i] == 0) begin
        m_px[i] = 639;
        m_py[i] = gap_table[m_gidx];
        m_gidx = (m_gidx + 1) % 4;
      end else begin
        m_px[i] = m_px[i] - 1;
      end
      if (m_px[i] == 59 && m_score < 999) m_score = m_score + 1;
    end
  endtask

  task automatic model_clk(input bit t, input bit f);
    bit feff;
    feff = m_pend || (f && !m_fprev);
    if (m_state == 1 && model_collide()) begin
      m_state = 2;
    end else if (t) begin
      if (m_state == 0 && feff) begin
        m_state = 1; m_score = 0; model_update(feff);
      end else if (m_state == 1) begin
        model_update(feff);
      end else if (m_state == 2 && feff) begin
        model_reload(); m_state = 0;
      end
    end
    m_pend = t ? 1'b0 : feff;
    m_fprev = f;
  endtask

  task automatic step(input bit t, input bit f);
    tick = t; flap = f;
    @(posedge clk);
    model_clk(t, f);
    #1;
  endtask

  function automatic int target_y();
    int best;
    best = -1;
    for (int i = 0; i < 2; i++)
      if (m_px[i] > 60 && (best < 0 || m_px[i] < m_px[best])) best = i;
    if (best < 0) best = 0;
    return m_py[best] + 70;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests++;
    if (dut_vec !== RESET_VEC) begin
      fails++; $display("[TB] FAIL reset_values: got %h expected %h", dut_vec, RESET_VEC);
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin step(0, 0); step(1, 0); end
    tests++;
    if (dut_vec !== RESET_VEC) begin
      fails++; $display("[TB] FAIL idle_frozen: got %h expected %h", dut_vec, RESET_VEC);
    end
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("[TB] FAIL idle_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_flap_start();
    int exp_y[7] = '{221, 217, 214, 212, 211, 211, 212};
    step(0, 1); step(0, 0); step(1, 0);
    tests++;
    if (playing !== 1'b1 || bird_y !== 11'd226) begin
      fails++; $display("[TB] FAIL flap_start: got playing=%b y=%0d expected playing=1 y=226", playing, bird_y);
    end
    for (int k = 0; k < 7; k++) begin
      step(0, 0); step(1, 0);
      tests++;
      if (bird_y !== 11'(exp_y[k])) begin
        fails++; $display("[TB] FAIL climb_y[%0d]: got %0d expected %0d", k, bird_y, exp_y[k]);
      end
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("[TB] FAIL climb_model[%0d]: got %h expected %h", k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_fall_to_floor();
    bit hit;
    logic [77:0] frozen;
    hit = 1'b0;
    for (int n = 0; n < 120 && !hit; n++) begin
      step(0, 0); step(1, 0);
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("[TB] FAIL fall_model: got %h expected %h", dut_vec, model_vec());
      end
      if (m_by >= 464) begin
        hit = 1'b1;
        tests++;
        if (game_over !== 1'b0) begin
          fails++; $display("[TB] FAIL floor_early: got game_over=%b expected 0", game_over);
        end
        step(0, 0);
        tests++;
        if (game_over !== 1'b1 || playing !== 1'b0) begin
          fails++; $display("[TB] FAIL floor_dead: got game_over=%b playing=%b expected 1/0", game_over, playing);
        end
      end
    end
    if (!hit) begin
      tests++; fails++;
      $display("[TB] FAIL floor_timeout: got no floor hit within 120 ticks, expected one");
    end
    frozen = model_vec();
    for (int k = 0; k < 5; k++) begin step(0, 0); step(1, 0); end
    tests++;
    if (dut_vec !== frozen) begin
      fails++; $display("[TB] FAIL dead_frozen: got %h expected %h", dut_vec, frozen);
    end
  endtask

  task automatic test_restart();
    step(0, 1); step(0, 0); step(1, 0);
    tests++;
    if (dut_vec[77:12] !== RESET_VEC[77:12] || playing !== 1'b0 || game_over !== 1'b0) begin
      fails++; $display("[TB] FAIL restart_idle: got %h expected %h", dut_vec, RESET_VEC);
    end
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("[TB] FAIL restart_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_pipe_play();
    bit pass_seen, wrap_seen, want, tf;
    int prev_score, prev_p1x, gap;
    pass_seen = 1'b0; wrap_seen = 1'b0;
    step(0, 1); step(0, 0); step(1, 0);
    for (int n = 0; n < 700; n++) begin
      want = (m_state == 1) && (m_vel >= 0) && (m_by >= target_y());
      gap = $urandom_range(0, 3);
      tf = 1'b0;
      if (want) begin
        case ($urandom_range(0, 2))
          0: begin repeat (gap) step(0, 0); tf = 1'b1; end
          1: begin step(0, 1); repeat (gap) step(0, 0); end
          default: begin step(0, 1); step(0, 0); step(0, 1); step(0, 0); end
        endcase
      end else begin
        repeat (gap) step(0, 0);
      end
      prev_score = m_score;
      prev_p1x = m_px[0];
      step(1, tf);
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("[TB] FAIL play_model[%0d]: got %h expected %h", n, dut_vec, model_vec());
      end
      if (m_state == 1 && prev_p1x == 60 && m_px[0] == 59) begin
        pass_seen = 1'b1;
        tests++;
        if (score !== 10'(prev_score + 1)) begin
          fails++; $display("[TB] FAIL score_pass: got %0d expected %0d", score, prev_score + 1);
        end
      end
      if (m_state == 1 && prev_p1x == 0) begin
        wrap_seen = 1'b1;
        tests++;
        if (pipe1_x !== 11'd639 || pipe1_y !== 11'd200) begin
          fails++; $display("[TB] FAIL pipe_wrap: got x=%0d y=%0d expected x=639 y=200", pipe1_x, pipe1_y);
        end
      end
      if (tf) step(0, 0);
    end
    tests++;
    if (!pass_seen || !wrap_seen) begin
      fails++; $display("[TB] FAIL pipe_events: got pass=%b wrap=%b expected 1/1", pass_seen, wrap_seen);
    end
  endtask

  task automatic test_reset_mid_play();
    reset = 1'b1;
    #2;
    tests++;
    if (dut_vec !== RESET_VEC) begin
      fails++; $display("[TB] FAIL async_reset: got %h expected %h", dut_vec, RESET_VEC);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    step(0, 1); step(0, 0); step(0, 1); step(0, 0); step(1, 0);
    tests++;
    if (bird_y !== 11'd226 || playing !== 1'b1) begin
      fails++; $display("[TB] FAIL double_edge: got y=%0d playing=%b expected 226/1", bird_y, playing);
    end
    step(0, 0); step(1, 0);
    tests++;
    if (bird_y !== 11'd221) begin
      fails++; $display("[TB] FAIL pend_cleared: got %0d expected 221", bird_y);
    end
    step(0, 0); step(1, 1);
    tests++;
    if (bird_y !== 11'd215) begin
      fails++; $display("[TB] FAIL flap_on_tick: got %0d expected 215", bird_y);
    end
    step(0, 0);
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("[TB] FAIL b2b_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_flap_start();
    test_fall_to_floor();
    test_restart();
    test_pipe_play();
    test_reset_mid_play();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
